// File: rtl/taxi_trip_ctrl.sv
// Taxi trip controller: debounced trip/move keys drive an IDLE/RUN/WAIT/HOLD FSM
// that accumulates distance (gongli) and waiting (dengdai) counts from a 1 ms tick.
module taxi_trip_ctrl #(
  parameter int unsigned DEB_CYCLES  = 500000,
  parameter int unsigned TICK_CYCLES = 50000,
  parameter int unsigned DIST_MS     = 100,
  parameter int unsigned WAIT_MS     = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_trip,
  input  logic        key_move,
  output logic [24:0] gongli,
  output logic [24:0] dengdai,
  output logic        trip_active,
  output logic        fare_freeze,
  output logic        dist_pulse,
  output logic        wait_pulse
);

  localparam int unsigned DEB_W  = $clog2(DEB_CYCLES + 1);
  localparam int unsigned TICK_W = $clog2(TICK_CYCLES + 1);
  localparam int unsigned DIST_W = $clog2(DIST_MS + 1);
  localparam int unsigned WAIT_W = $clog2(WAIT_MS + 1);
  localparam logic [24:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_HOLD} state_t;

  state_t             state, state_nx;
  logic [1:0]         key_p0, key_p1, key_deb;   // bit 0 = trip, bit 1 = move
  logic [DEB_W-1:0]   deb_cnt [2];
  logic               trip_deb_d;
  logic [1:0]         flush;
  logic               trip_armed;
  logic [TICK_W-1:0]  tick_cnt;
  logic               tick, trip_evt, move_deb;
  logic [DIST_W-1:0]  dist_acc;
  logic [WAIT_W-1:0]  wait_acc;

  function automatic logic [24:0] sat_inc(input logic [24:0] v);
    return (v == CNT_MAX) ? v : v + 25'd1;
  endfunction

  // Synchronizer and debounce stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_p0     <= 2'b11;
      key_p1     <= 2'b11;
      key_deb    <= 2'b11;
      trip_deb_d <= 1'b1;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
      flush      <= '0;
      trip_armed <= 1'b0;
    end else begin
      key_p0     <= {key_move, key_trip};
      key_p1     <= key_p0;
      trip_deb_d <= key_deb[0];
      flush      <= {flush[0], 1'b1};
      // A press held through reset must be released before it can start a trip.
      if (flush[1] && key_p1[0]) trip_armed <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (key_p1[i] == key_deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
          deb_cnt[i] <= '0;
          key_deb[i] <= key_p1[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  assign trip_evt = trip_armed & trip_deb_d & ~key_deb[0];
  assign move_deb = key_deb[1];
  assign tick     = (tick_cnt == TICK_W'(TICK_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_cnt <= '0;
    else        tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (trip_evt) state_nx = move_deb ? S_WAIT : S_RUN;
      S_RUN: begin
        if (trip_evt)      state_nx = S_HOLD;
        else if (move_deb) state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (trip_evt)       state_nx = S_HOLD;
        else if (!move_deb) state_nx = S_RUN;
      end
      S_HOLD: if (trip_evt) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State, accumulator and output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      dist_acc    <= '0;
      wait_acc    <= '0;
      gongli      <= '0;
      dengdai     <= '0;
      dist_pulse  <= 1'b0;
      wait_pulse  <= 1'b0;
      trip_active <= 1'b0;
      fare_freeze <= 1'b0;
    end else begin
      state       <= state_nx;
      trip_active <= (state_nx == S_RUN) || (state_nx == S_WAIT);
      fare_freeze <= (state_nx == S_HOLD);
      dist_pulse  <= 1'b0;
      wait_pulse  <= 1'b0;
      if (state_nx != state) begin
        dist_acc <= '0;
        wait_acc <= '0;
        if (state == S_HOLD) begin
          gongli  <= '0;
          dengdai <= '0;
        end
      end else if (tick && state == S_RUN) begin
        if (dist_acc == DIST_W'(DIST_MS - 1)) begin
          dist_acc   <= '0;
          gongli     <= sat_inc(gongli);
          dist_pulse <= (gongli != CNT_MAX);
        end else begin
          dist_acc <= dist_acc + DIST_W'(1);
        end
      end else if (tick && state == S_WAIT) begin
        if (wait_acc == WAIT_W'(WAIT_MS - 1)) begin
          wait_acc   <= '0;
          dengdai    <= sat_inc(dengdai);
          wait_pulse <= (dengdai != CNT_MAX);
        end else begin
          wait_acc <= wait_acc + WAIT_W'(1);
        end
      end
    end
  end

endmodule
